qd_counter: RTL and testbench

Parametrised successor to the motor quadrature decoder.
- Synchronises and glitch-filters the A/B encoder channels, then performs x4 decoding.
- Keeps a signed position count, a direction flag and a sticky illegal-transition flag.
- Measures velocity as signed steps per fixed window.
- Sits between the motor encoder pins and the speed/position control logic. One instance per wheel.

---
 rtl/qd_counter_if.sv | 21 ++
 rtl/qd_counter.sv | 124 ++++++++++++
 tb/tb_qd_counter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qd_counter_if.sv
// qd_counter_if: encoder pins, clear and decoded outputs of one qd_counter wheel channel.
// The Z index signal exists only when QD_INDEX_EN is defined.
interface qd_counter_if #(
   parameter int CNT_W = 16,
   parameter int VEL_W = 12
);
   logic A, B, clr;
`ifdef QD_INDEX_EN
   logic Z;
`endif
   logic [CNT_W-1:0] pos;
   logic [VEL_W-1:0] vel;
   logic dir, step, err, vel_valid;
`ifdef QD_INDEX_EN
   modport master (output A, B, Z, clr, input pos, dir, step, err, vel, vel_valid);
   modport slave (input A, B, Z, clr, output pos, dir, step, err, vel, vel_valid);
`else
   modport master (output A, B, clr, input pos, dir, step, err, vel, vel_valid);
   modport slave (input A, B, clr, output pos, dir, step, err, vel, vel_valid);
`endif
endinterface

// File: rtl/qd_counter.sv
// qd_counter: filtered x4 quadrature decoder with signed position, direction, sticky error and windowed velocity.
// Defining QD_INDEX_EN adds a filtered Z index input whose rising edge zeroes the position.
module qd_counter #(
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 3,
   parameter int VEL_WIN  = 50000,
   parameter int VEL_W    = 12
) (
   input logic clk,
   input logic rst,
   qd_counter_if.slave bus
);
   localparam int WW = $clog2(VEL_WIN);
   localparam int AW = $clog2(VEL_WIN + 1) + 1;
   localparam int VMAX = 2 ** (VEL_W - 1) - 1;
   localparam int VMIN = -(2 ** (VEL_W - 1));
   localparam logic [3:0] QUAL = 4'(FILT_LEN - 1);
   typedef enum logic {INIT, TRACK} state_t;
   state_t state_q, state_d;
   logic [2:0] vld_q, vld_d;
   logic [1:0] sync1_q, sync2_q, cand_q, fab_q, fab_d, idx_old, idx_new, delta;
   logic [3:0] cnt_q, cnt_d;
   logic eq, qual, fwd, rev, bad, zero;
   logic signed [CNT_W-1:0] pos_q, pos_d;
   logic dir_q, dir_d, step_q, step_d, err_q, err_d, vv_q, vv_d;
   logic [WW-1:0] win_q, win_d;
   logic signed [AW-1:0] acc_q, acc_d, acc_n;
   logic signed [31:0] acc_w;
   logic signed [VEL_W-1:0] vel_q, vel_d;
`ifdef QD_INDEX_EN
   logic zs1_q, zs2_q, zc_q, zf_q, zf_d, zeq, zqual;
   logic [3:0] zn_q, zn_d;
`endif
   always_comb begin
      // Nothing qualifies until the sync chain and candidate hold real pin samples, so reset values never decode.
      vld_d = {vld_q[1:0], 1'b1};
      eq = vld_q[2] && sync2_q == cand_q;
      qual = eq && cnt_q == QUAL;
      cnt_d = eq ? cnt_q + 4'(cnt_q != 4'hf) : 4'd0;
      fab_d = qual ? cand_q : fab_q;
      state_d = qual ? TRACK : state_q;
      // Gray to binary phase index: a forward step adds 1 modulo 4, a double-bit change adds 2.
      idx_old = {fab_q[1], ^fab_q};
      idx_new = {cand_q[1], ^cand_q};
      delta = idx_new - idx_old;
      fwd = qual && state_q == TRACK && delta == 2'd1;
      rev = qual && state_q == TRACK && delta == 2'd3;
      bad = qual && state_q == TRACK && delta == 2'd2;
`ifdef QD_INDEX_EN
      zeq = vld_q[2] && zs2_q == zc_q;
      zqual = zeq && zn_q == QUAL;
      zn_d = zeq ? zn_q + 4'(zn_q != 4'hf) : 4'd0;
      zf_d = zqual ? zc_q : zf_q;
      zero = bus.clr || (zqual && zc_q && !zf_q && state_q == TRACK);
`else
      zero = bus.clr;
`endif
      pos_d = zero ? '0 : pos_q + CNT_W'(fwd) - CNT_W'(rev);
      dir_d = fwd ? 1'b1 : rev ? 1'b0 : dir_q;
      step_d = fwd || rev;
      err_d = !bus.clr && (err_q || bad);
      vv_d = win_q == WW'(VEL_WIN - 1);
      win_d = vv_d ? '0 : win_q + WW'(1);
      acc_n = acc_q + AW'(fwd) - AW'(rev);
      acc_w = 32'(acc_n);
      acc_d = vv_d ? '0 : acc_n;
      vel_d = !vv_d ? vel_q : acc_w > VMAX ? VEL_W'(VMAX) : acc_w < VMIN ? VEL_W'(VMIN) : VEL_W'(acc_w);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT;
         vld_q <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q <= '0;
         cnt_q <= '0;
         fab_q <= '0;
         pos_q <= '0;
         dir_q <= 1'b0;
         step_q <= 1'b0;
         err_q <= 1'b0;
         win_q <= '0;
         acc_q <= '0;
         vel_q <= '0;
         vv_q <= 1'b0;
`ifdef QD_INDEX_EN
         zs1_q <= 1'b0;
         zs2_q <= 1'b0;
         zc_q <= 1'b0;
         zn_q <= '0;
         zf_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         vld_q <= vld_d;
         sync1_q <= {bus.A, bus.B};
         sync2_q <= sync1_q;
         cand_q <= sync2_q;
         cnt_q <= cnt_d;
         fab_q <= fab_d;
         pos_q <= pos_d;
         dir_q <= dir_d;
         step_q <= step_d;
         err_q <= err_d;
         win_q <= win_d;
         acc_q <= acc_d;
         vel_q <= vel_d;
         vv_q <= vv_d;
`ifdef QD_INDEX_EN
         zs1_q <= bus.Z;
         zs2_q <= zs1_q;
         zc_q <= zs2_q;
         zn_q <= zn_d;
         zf_q <= zf_d;
`endif
      end
   end
   assign bus.pos = pos_q;
   assign bus.dir = dir_q;
   assign bus.step = step_q;
   assign bus.err = err_q;
   assign bus.vel = vel_q;
   assign bus.vel_valid = vv_q;
endmodule

// File: tb/tb_qd_counter.sv
// tb_qd_counter: directed encoder patterns checked every cycle against a behavioural decoder model,
// plus hand-computed spot checks; the index scenario runs only when QD_INDEX_EN is defined.
module tb_qd_counter;
   localparam int CNT_W = 16;
   localparam int FILT_LEN = 3;
   localparam int VEL_WIN = 100;
   localparam int VEL_W = 12;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   qd_counter_if #(.CNT_W(CNT_W), .VEL_W(VEL_W)) bus ();
   qd_counter #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN), .VEL_W(VEL_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // Phase of each {A,B} level along the forward sequence 00 -> 01 -> 11 -> 10.
   int gidx [4] = '{0, 1, 3, 2};
   int cyc, winc, acc;
   int last_v [2];
   int run_n [2];
   int fire_at [2];
   int fire_v [2];
   bit trk, zf;
   logic [1:0] fab;
   logic [CNT_W-1:0] m_pos;
   logic [VEL_W-1:0] m_vel;
   logic m_dir, m_step, m_err, m_vv;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic void mreset();
      cyc = 0;
      winc = 0;
      acc = 0;
      trk = 0;
      zf = 0;
      fab = 2'b00;
      m_pos = '0;
      m_vel = '0;
      m_dir = 0;
      m_step = 0;
      m_err = 0;
      m_vv = 0;
      for (int c = 0; c < 2; c++) begin
         last_v[c] = -1;
         run_n[c] = 0;
         fire_at[c] = -1;
         fire_v[c] = 0;
      end
   endfunction
   // A level counts once it has been sampled FILT_LEN+1 times in a row; it takes effect two edges later.
   task automatic mstep(input logic [1:0] ab, input logic z, input logic clr);
      int smp [2];
      bit q [2];
      int v [2];
      bit fwd, rev, bad, zrise;
      int d;
      cyc++;
      smp[0] = int'(ab);
      smp[1] = int'(z);
      for (int c = 0; c < 2; c++) begin
         q[c] = fire_at[c] == cyc;
         v[c] = fire_v[c];
         run_n[c] = smp[c] == last_v[c] ? run_n[c] + 1 : 1;
         last_v[c] = smp[c];
         if (run_n[c] == FILT_LEN + 1) begin
            fire_at[c] = cyc + 2;
            fire_v[c] = smp[c];
         end
      end
      fwd = 0;
      rev = 0;
      bad = 0;
      zrise = trk && q[1] && v[1] == 1 && !zf;
      if (q[1]) zf = v[1] != 0;
      if (q[0]) begin
         if (trk && v[0] != int'(fab)) begin
            d = (gidx[v[0]] - gidx[fab]) & 3;
            fwd = d == 1;
            rev = d == 3;
            bad = d == 2;
         end
         trk = 1;
         fab = 2'(v[0]);
      end
      m_step = fwd || rev;
      if (fwd) m_dir = 1;
      else if (rev) m_dir = 0;
      if (clr || zrise) m_pos = '0;
      else if (fwd) m_pos = m_pos + 1'b1;
      else if (rev) m_pos = m_pos - 1'b1;
      m_err = clr ? 1'b0 : (m_err | bad);
      acc += int'(fwd) - int'(rev);
      m_vv = winc == VEL_WIN - 1;
      if (m_vv) begin
         m_vel = VEL_W'(acc > 2047 ? 2047 : acc < -2048 ? -2048 : acc);
         acc = 0;
         winc = 0;
      end else winc++;
   endtask
   always @(negedge rst) mreset();
   initial forever begin
      @(posedge clk);
`ifdef QD_INDEX_EN
      if (rst) mstep({bus.A, bus.B}, bus.Z, bus.clr);
`else
      if (rst) mstep({bus.A, bus.B}, 1'b0, bus.clr);
`endif
      #1;
      check("pos", 32'(bus.pos), 32'(m_pos));
      check("dir", 32'(bus.dir), 32'(m_dir));
      check("step", 32'(bus.step), 32'(m_step));
      check("err", 32'(bus.err), 32'(m_err));
      check("vel", 32'(bus.vel), 32'(m_vel));
      check("vel_valid", 32'(bus.vel_valid), 32'(m_vv));
   end
   task automatic set_ab(input logic [1:0] v);
      bus.A = v[1];
      bus.B = v[0];
   endtask
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   logic [1:0] vel_seq [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
   logic [1:0] idx_seq [7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
   int n;
   initial begin
      mreset();
      set_ab(2'b11);
      bus.clr = 1'b0;
`ifdef QD_INDEX_EN
      bus.Z = 1'b0;
`endif
      wait_n(3);
      check("reset_pos", 32'(bus.pos), 0);
      check("reset_err", 32'(bus.err), 0);
      check("reset_vel_valid", 32'(bus.vel_valid), 0);
      rst = 1'b1;
      wait_n(10);
      check("init11_err", 32'(bus.err), 0);
      check("init11_pos", 32'(bus.pos), 0);
      set_ab(2'b00);
      rst = 1'b0;
      wait_n(2);
      rst = 1'b1;
      wait_n(8);
      set_ab(2'b01);
      wait_n(5);
      check("latency_step_early", 32'(bus.step), 0);
      wait_n(1);
      check("latency_step", 32'(bus.step), 1);
      wait_n(2);
      set_ab(2'b11);
      wait_n(8);
      set_ab(2'b10);
      wait_n(8);
      set_ab(2'b00);
      wait_n(8);
      check("fwd_pos", 32'(bus.pos), 4);
      check("fwd_dir", 32'(bus.dir), 1);
      bus.clr = 1'b1;
      wait_n(1);
      bus.clr = 1'b0;
      check("clr_pos", 32'(bus.pos), 0);
      set_ab(2'b10);
      wait_n(8);
      check("rev_pos", 32'(bus.pos), 32'h0000_ffff);
      check("rev_dir", 32'(bus.dir), 0);
      set_ab(2'b11);
      wait_n(2);
      set_ab(2'b10);
      wait_n(8);
      check("glitch_pos", 32'(bus.pos), 32'h0000_ffff);
      set_ab(2'b01);
      wait_n(8);
      check("illegal_err", 32'(bus.err), 1);
      check("illegal_pos", 32'(bus.pos), 32'h0000_ffff);
      check("illegal_dir", 32'(bus.dir), 0);
      set_ab(2'b11);
      wait_n(5);
      bus.clr = 1'b1;
      wait_n(1);
      bus.clr = 1'b0;
      check("clr_step_step", 32'(bus.step), 1);
      check("clr_step_pos", 32'(bus.pos), 0);
      check("clr_step_err", 32'(bus.err), 0);
      check("clr_step_dir", 32'(bus.dir), 1);
      wait_n(3);
      foreach (idx_seq[i]) if (i < 5) begin
         set_ab(idx_seq[i + 1]);
         wait_n(8);
      end
      check("pre_reset_pos", 32'(bus.pos), 5);
      #3 rst = 1'b0;
      #1;
      check("async_pos", 32'(bus.pos), 0);
      check("async_dir", 32'(bus.dir), 0);
      check("async_step", 32'(bus.step), 0);
      check("async_err", 32'(bus.err), 0);
      check("async_vel", 32'(bus.vel), 0);
      @(negedge clk);
      rst = 1'b1;
      wait_n(8);
      foreach (vel_seq[i]) begin
         set_ab(vel_seq[i]);
         wait_n(8);
      end
      n = 0;
      while (!bus.vel_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("vel_pulse", 32'(bus.vel_valid), 1);
      check("vel_cycle", 32'(cyc), 100);
      check("vel_value", 32'(bus.vel), 10);
      @(negedge clk);
      check("vel_single_pulse", 32'(bus.vel_valid), 0);
      n = 0;
      while (!bus.vel_valid && n < 150) begin
         @(negedge clk);
         n++;
      end
      check("vel2_pulse", 32'(bus.vel_valid), 1);
      check("vel2_cycle", 32'(cyc), 200);
      check("vel2_value", 32'(bus.vel), 0);
`ifdef QD_INDEX_EN
      bus.clr = 1'b1;
      wait_n(1);
      bus.clr = 1'b0;
      foreach (idx_seq[i]) begin
         set_ab(idx_seq[i]);
         wait_n(8);
      end
      check("index_pre_pos", 32'(bus.pos), 7);
      bus.Z = 1'b1;
      wait_n(8);
      check("index_pos", 32'(bus.pos), 0);
      bus.Z = 1'b0;
      wait_n(8);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
